// File: rtl/fp8_alu.sv
// -----------------------------------------------------------------------------
// fp8_alu -- multi-cycle FP8 E4M3 add / multiply leaf.
//
// Format: 1 sign bit, 4 exponent bits (bias 7), 3 mantissa bits. An exponent
// field of 0 reads as zero (subnormals flush). Inf/NaN encodings are ordinary
// numbers here, and the unit never produces NaN: overflow saturates to +/-448.
//
// One operation runs per reset release: LOAD -> EXEC -> NORM -> DONE. The
// result appears with is_output_valid on the 4th rising edge after reset is
// released (LATENCY = 4, fixed). DONE then holds until the next reset.
//
// Ports (in fixed positional order):
//   a, b            in  [7:0]  operands, FP8 E4M3
//   alu_ctrl        in  [3:0]  4'b0001 = ADD, 4'b0010 = MUL, others reserved
//                              (a reserved code gives y = 8'h00, still valid)
//   clock           in         rising-edge clock
//   reset           in         asynchronous, active low; 0 aborts and clears
//   y               out [7:0]  result, FP8 E4M3
//   is_output_valid out        high while y holds the final result
// -----------------------------------------------------------------------------
module fp8_alu (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] alu_ctrl,
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] y,
  output logic       is_output_valid
);

  typedef enum logic [1:0] {S_LOAD, S_EXEC, S_NORM, S_DONE} state_e;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;

  state_e            state_q, state_d;
  logic [7:0]        a_q, a_d, b_q, b_d;
  logic [3:0]        op_q, op_d;
  // Raw EXEC result: ADD keeps a 5-bit magnitude in r_sig[4:0], MUL the full
  // 8-bit significand product.
  logic              r_sign_q, r_sign_d;
  logic signed [5:0] r_exp_q, r_exp_d;
  logic [7:0]        r_sig_q, r_sig_d;
  logic              r_zero_q, r_zero_d;
  logic [7:0]        res_q, res_d;
  logic [7:0]        y_q, y_d;
  logic              valid_q, valid_d;

  // Leading-zero count of a nonzero 4-bit magnitude.
  function automatic logic [1:0] lzc4(input logic [3:0] v);
    casez (v)
      4'b1???: lzc4 = 2'd0;
      4'b01??: lzc4 = 2'd1;
      4'b001?: lzc4 = 2'd2;
      default: lzc4 = 2'd3;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Operand unpack (from the registered operands)
  // ---------------------------------------------------------------------------
  logic       sa, sb, za, zb;
  logic [3:0] ea, eb, ma, mb;

  assign sa = a_q[7];
  assign sb = b_q[7];
  assign ea = a_q[6:3];
  assign eb = b_q[6:3];
  assign za = (ea == 4'd0);
  assign zb = (eb == 4'd0);
  // A zero exponent clears the hidden bit and the mantissa, so a flushed
  // operand has magnitude exactly 0 and sorts below every normal number.
  assign ma = za ? 4'd0 : {1'b1, a_q[2:0]};
  assign mb = zb ? 4'd0 : {1'b1, b_q[2:0]};

  // ---------------------------------------------------------------------------
  // EXEC datapath
  // ---------------------------------------------------------------------------
  logic              a_ge_b, sl;
  logic [3:0]        el, es, ml, ms, shift_amt, aligned;
  logic [4:0]        add_mag;
  logic signed [5:0] mul_exp;
  logic [7:0]        mul_prod;

  always_comb begin
    // Exponent is the primary sort key, so el >= es and the shift is never
    // negative.
    a_ge_b    = {ea, ma} >= {eb, mb};
    sl        = a_ge_b ? sa : sb;
    el        = a_ge_b ? ea : eb;
    es        = a_ge_b ? eb : ea;
    ml        = a_ge_b ? ma : mb;
    ms        = a_ge_b ? mb : ma;
    shift_amt = el - es;
    // A shift of 4 or more empties the 4-bit significand, as intended.
    aligned   = ms >> shift_amt;
    add_mag   = (sa == sb) ? ({1'b0, ml} + {1'b0, aligned})
                           : ({1'b0, ml} - {1'b0, aligned});
    mul_exp   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 6'sd7;
    mul_prod  = {4'd0, ma} * {4'd0, mb};
  end

  // ---------------------------------------------------------------------------
  // NORM datapath: leading-1 renormalize, truncate, then range handling
  // ---------------------------------------------------------------------------
  logic signed [5:0] n_exp;
  logic [2:0]        n_mant;
  logic [1:0]        lz;
  logic [7:0]        packed_res;

  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first,
    // so no path can leave it unassigned and infer a latch.
    n_exp      = r_exp_q;
    n_mant     = 3'd0;
    lz         = lzc4(r_sig_q[3:0]);
    packed_res = 8'h00;

    if (op_q == OP_ADD) begin
      if (r_sig_q[4]) begin
        // Carry out of the add: drop one bit off the bottom.
        n_mant = r_sig_q[3:1];
        n_exp  = r_exp_q + 6'sd1;
      end else begin
        // Cancellation: pull the leading 1 up to the hidden-bit position.
        n_mant = r_sig_q[2:0] << lz;
        n_exp  = r_exp_q - $signed({4'b0000, lz});
      end
    end else begin
      // 1.xxx * 1.yyy lies in [1, 4); bit 7 set means the product is >= 2.
      if (r_sig_q[7]) begin
        n_mant = r_sig_q[6:4];
        n_exp  = r_exp_q + 6'sd1;
      end else begin
        n_mant = r_sig_q[5:3];
      end
    end

    if (((op_q != OP_ADD) && (op_q != OP_MUL)) || r_zero_q) begin
      // Reserved opcodes and exact zeros always give +0, never 8'h80.
      packed_res = 8'h00;
    end else if (n_exp <= 6'sd0) begin
      packed_res = {r_sign_q, 7'd0};
    end else if ((n_exp > 6'sd15) || ((n_exp == 6'sd15) && (n_mant == 3'b111))) begin
      // S.1111.111 would be NaN; the largest finite value is S.1111.110.
      packed_res = {r_sign_q, 4'b1111, 3'b110};
    end else begin
      packed_res = {r_sign_q, n_exp[3:0], n_mant};
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and register updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    r_sign_d = r_sign_q;
    r_exp_d  = r_exp_q;
    r_sig_d  = r_sig_q;
    r_zero_d = r_zero_q;
    res_d    = res_q;
    y_d      = y_q;
    valid_d  = valid_q;

    unique case (state_q)
      S_LOAD: begin
        a_d     = a;
        b_d     = b;
        op_d    = alu_ctrl;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op_q == OP_MUL) begin
          r_sign_d = sa ^ sb;
          r_exp_d  = mul_exp;
          r_sig_d  = mul_prod;
          r_zero_d = za | zb;
        end else begin
          // Reserved opcodes also take this path; NORM forces their result
          // to zero regardless.
          r_sign_d = sl;
          r_exp_d  = $signed({2'b00, el});
          r_sig_d  = {3'd0, add_mag};
          r_zero_d = (add_mag == 5'd0);
        end
        state_d = S_NORM;
      end
      S_NORM: begin
        res_d   = packed_res;
        state_d = S_DONE;
      end
      S_DONE: begin
        // The operands were captured only in LOAD, so res_q is stable here
        // and later input changes cannot disturb y.
        y_d     = res_q;
        valid_d = 1'b1;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  // The datapath registers are reset too: there are few of them, and a clean
  // reset keeps every state of this one-shot unit deterministic.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_LOAD;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      op_q     <= 4'h0;
      r_sign_q <= 1'b0;
      r_exp_q  <= 6'sd0;
      r_sig_q  <= 8'h00;
      r_zero_q <= 1'b1;
      res_q    <= 8'h00;
      y_q      <= 8'h00;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      r_sign_q <= r_sign_d;
      r_exp_q  <= r_exp_d;
      r_sig_q  <= r_sig_d;
      r_zero_q <= r_zero_d;
      res_q    <= res_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
    end
  end

  assign y               = y_q;
  assign is_output_valid = valid_q;

endmodule

// File: tb/tb_fp8_alu.sv
// -----------------------------------------------------------------------------
// tb_fp8_alu -- self-checking bench for fp8_alu.
// Each operation pushes its expected result onto a scoreboard queue when it is
// launched; the entry is popped and compared when is_output_valid is observed.
// Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fp8_alu;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [3:0] alu_ctrl = 4'h0;
  logic [7:0] y;
  logic       is_output_valid;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  fp8_alu dut (
    .a              (a),
    .b              (b),
    .alu_ctrl       (alu_ctrl),
    .clock          (clock),
    .reset          (reset),
    .y              (y),
    .is_output_valid(is_output_valid)
  );

  always #5 clock = ~clock;

  // Hold reset for one cycle with the new operands applied, record the
  // expected result, then release reset on a falling edge.
  task automatic start_op(input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic [3:0] op, input logic [7:0] exp_y);
    @(negedge clock);
    reset    = 1'b0;
    a        = op_a;
    b        = op_b;
    alu_ctrl = op;
    sb_q.push_back(exp_y);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Count rising edges after release until valid is seen (bounded).
  // edges == 0 on return means the bound expired.
  task automatic wait_result(output logic [7:0] got, output int edges);
    got   = 8'h00;
    edges = 0;
    for (int i = 1; i <= 10 && edges == 0; i++) begin
      @(negedge clock);
      if (is_output_valid === 1'b1) begin
        edges = i;
        got   = y;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (y !== 8'h00) begin
      errors++;
      $display("FAIL reset_y: got %02h expected 00", y);
    end
    checks++;
    if (is_output_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", is_output_valid);
    end
  endtask

  task automatic test_add;
    logic [7:0] va [3] = '{8'h40, 8'h28, 8'h50};
    logic [7:0] vb [3] = '{8'h40, 8'h10, 8'h10};
    logic [7:0] vy [3] = '{8'h48, 8'h29, 8'h50};
    logic [7:0] got, expv;
    int edges;
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i], OP_ADD, vy[i]);
      wait_result(got, edges);
      expv = sb_q.pop_front();
      checks++;
      if (edges !== 4) begin
        errors++;
        $display("FAIL add_latency %02h+%02h: valid after %0d edges expected 4", va[i], vb[i], edges);
      end
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL add %02h+%02h: got %02h expected %02h", va[i], vb[i], got, expv);
      end
    end
  endtask

  task automatic test_add_signed;
    logic [7:0] va [4] = '{8'h50, 8'h41, 8'h48, 8'hC8};
    logic [7:0] vb [4] = '{8'hD0, 8'hC0, 8'hD0, 8'hD0};
    logic [7:0] vy [4] = '{8'h00, 8'h28, 8'hC8, 8'hD4};
    logic [7:0] got, expv;
    int edges;
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i], OP_ADD, vy[i]);
      wait_result(got, edges);
      expv = sb_q.pop_front();
      checks++;
      if (edges !== 4) begin
        errors++;
        $display("FAIL add_signed_latency %02h+%02h: valid after %0d edges expected 4", va[i], vb[i], edges);
      end
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL add_signed %02h+%02h: got %02h expected %02h", va[i], vb[i], got, expv);
      end
    end
  endtask

  task automatic test_mul;
    // The last two rows are saturation and underflow.
    logic [7:0] va [8] = '{8'h40, 8'h38, 8'h38, 8'h40, 8'hAC, 8'h00, 8'h77, 8'h08};
    logic [7:0] vb [8] = '{8'h40, 8'h38, 8'hB8, 8'h39, 8'hC0, 8'h00, 8'h77, 8'h08};
    logic [7:0] vy [8] = '{8'h48, 8'h38, 8'hB8, 8'h41, 8'h34, 8'h00, 8'h7E, 8'h00};
    logic [7:0] got, expv;
    int edges;
    for (int i = 0; i < 8; i++) begin
      start_op(va[i], vb[i], OP_MUL, vy[i]);
      wait_result(got, edges);
      expv = sb_q.pop_front();
      checks++;
      if (edges !== 4) begin
        errors++;
        $display("FAIL mul_latency %02h*%02h: valid after %0d edges expected 4", va[i], vb[i], edges);
      end
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL mul %02h*%02h: got %02h expected %02h", va[i], vb[i], got, expv);
      end
    end
  endtask

  task automatic test_reserved;
    logic [3:0] vop [2] = '{4'b0000, 4'b1111};
    logic [7:0] got, expv;
    int edges;
    for (int i = 0; i < 2; i++) begin
      start_op(8'h40, 8'h40, vop[i], 8'h00);
      wait_result(got, edges);
      expv = sb_q.pop_front();
      checks++;
      if (edges !== 4) begin
        errors++;
        $display("FAIL reserved_latency op=%b: valid after %0d edges expected 4", vop[i], edges);
      end
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL reserved op=%b: got %02h expected %02h", vop[i], got, expv);
      end
    end
  endtask

  task automatic test_hold;
    logic [7:0] got, expv;
    int edges;
    start_op(8'h40, 8'h40, OP_ADD, 8'h48);
    wait_result(got, edges);
    expv = sb_q.pop_front();
    a        = 8'h77;
    b        = 8'hD0;
    alu_ctrl = OP_MUL;
    repeat (3) @(negedge clock);
    checks++;
    if (y !== expv) begin
      errors++;
      $display("FAIL hold_y: got %02h expected %02h", y, expv);
    end
    checks++;
    if (is_output_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_valid: got %b expected 1", is_output_valid);
    end
  endtask

  task automatic test_midreset;
    logic [7:0] got, expv;
    int edges;
    // Asynchronous clear from DONE, well away from any rising edge.
    start_op(8'h38, 8'hB8, OP_MUL, 8'hB8);
    wait_result(got, edges);
    expv = sb_q.pop_front();
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL pre_reset_result: got %02h expected %02h", got, expv);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (y !== 8'h00 || is_output_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_clear_done: y=%02h valid=%b expected 00/0", y, is_output_valid);
    end

    // Abort in flight after two edges, then launch a fresh operation.
    start_op(8'h40, 8'h40, OP_MUL, 8'h48);
    repeat (2) @(negedge clock);
    checks++;
    if (is_output_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_valid: got %b expected 0 after 2 edges", is_output_valid);
    end
    #2 reset = 1'b0;
    // The aborted operation never produces an output; drop its entry.
    void'(sb_q.pop_back());
    #1;
    checks++;
    if (y !== 8'h00 || is_output_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_abort: y=%02h valid=%b expected 00/0", y, is_output_valid);
    end
    a        = 8'h28;
    b        = 8'h10;
    alu_ctrl = OP_ADD;
    sb_q.push_back(8'h29);
    @(negedge clock);
    reset = 1'b1;
    wait_result(got, edges);
    expv = sb_q.pop_front();
    checks++;
    if (edges !== 4) begin
      errors++;
      $display("FAIL restart_latency: valid after %0d edges expected 4", edges);
    end
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL restart_result: got %02h expected %02h", got, expv);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_signed();
    test_mul();
    test_reserved();
    test_hold();
    test_midreset();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
